spi_sram_responder: RTL

Synthesizable SPI mode-0 responder that emulates a single-bit serial SRAM of the 23LC family: READ, WRITE and read-mode-register commands in sequential mode, backed by an internal byte array. It is the target-side counterpart of our SRAM SPI controller. It plugs onto the PMOD expanded-SPI pins, giving FPGA prototypes and gate-level benches a self-contained memory behind the real controller pins. All SPI inputs are oversampled in the single system clock domain.

---
 rtl/spi_sram_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_sram_responder.sv
// spi_sram_responder
//   SPI mode-0 target emulating a 23LC-style serial SRAM in sequential mode.
//   Supports READ (0x03), WRITE (0x02) and RDMR (0x05); all other commands
//   are ignored until chip select rises. All SPI pins are oversampled in the
//   clk_i domain through 2-FF synchronisers.
//
// Ports:
//   clk_i        system clock (only clock)
//   rst_i        asynchronous active-high reset
//   spi_cs_n     chip select, active low (asynchronous)
//   spi_sck      serial clock, mode 0 (asynchronous)
//   spi_mosi     serial data in, MSB first
//   spi_miso     serial data out, MSB first
//   spi_miso_oe  output enable for spi_miso
//   busy_o       high while a recognised command is in progress
//   wr_strobe_o  one-cycle pulse per committed write byte
module spi_sram_responder #(
    parameter int         DEPTH        = 256,
    parameter logic [7:0] STATUS_VALUE = 8'h40
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_cs_n,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic busy_o,
    output logic wr_strobe_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, RDATA, STATUS, IGNORE
    } state_t;

    state_t state, state_n;

    logic          cs_s1, cs_s2;
    logic          sck_s1, sck_s2, sck_s3;
    logic          mosi_s1, mosi_s2;
    logic [2:0]    bit_cnt;
    logic [7:0]    in_sr;
    logic [7:0]    out_sr;
    logic          byte_done;
    logic [AW-1:0] addr;
    logic [1:0]    addr_cnt;
    logic          is_read;

    logic [7:0]    mem [DEPTH];

    logic sck_rise, sck_fall, byte_evt, mem_we, out_state;

    // sck_s3 is the third stage: edge pulses act exactly 3 cycles after the pin.
    assign sck_rise  = sck_s2 & ~sck_s3 & ~cs_s2;
    assign sck_fall  = ~sck_s2 & sck_s3 & ~cs_s2;
    // byte_done is registered one cycle after the wrapping rise so that in_sr
    // already holds the full byte when the FSM consumes it.
    assign byte_evt  = byte_done & ~cs_s2;
    assign mem_we    = (state == WDATA) & byte_evt;
    assign out_state = (state == RDATA) | (state == STATUS);

    assign spi_miso    = out_sr[7];
    assign spi_miso_oe = out_state & ~cs_s2;
    assign busy_o      = (state == ADDR) | (state == WDATA) | out_state;
    assign wr_strobe_o = mem_we;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (cs_s2) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = CMD;
                CMD: if (byte_done) begin
                    case (in_sr)
                        8'h02, 8'h03: state_n = ADDR;
                        8'h05:        state_n = STATUS;
                        default:      state_n = IGNORE;
                    endcase
                end
                ADDR: if (byte_done && addr_cnt == 2'd2)
                    state_n = is_read ? RDATA : WDATA;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // CS synchronisers reset to the deasserted level.
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_s3    <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            bit_cnt   <= 3'd0;
            in_sr     <= 8'h00;
            out_sr    <= 8'h00;
            byte_done <= 1'b0;
            addr      <= '0;
            addr_cnt  <= 2'd0;
            is_read   <= 1'b0;
        end else begin
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;

            byte_done <= 1'b0;
            if (cs_s2) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                in_sr     <= {in_sr[6:0], mosi_s2};
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= (bit_cnt == 3'd7);
            end

            if (byte_evt) begin
                case (state)
                    CMD: begin
                        is_read  <= (in_sr == 8'h03);
                        addr_cnt <= 2'd0;
                    end
                    ADDR: begin
                        // Shift bytes in big-endian; only the low AW bits survive.
                        addr     <= AW'({addr, in_sr});
                        addr_cnt <= addr_cnt + 2'd1;
                    end
                    WDATA:   addr <= addr + AW'(1);
                    default: ;
                endcase
            end

            // Byte boundary on the fall after the wrapping rise (bit_cnt back at 0).
            if (sck_fall && out_state) begin
                if (bit_cnt == 3'd0) begin
                    if (state == RDATA) begin
                        out_sr <= mem[addr];
                        addr   <= addr + AW'(1);
                    end else begin
                        out_sr <= STATUS_VALUE;
                    end
                end else begin
                    out_sr <= {out_sr[6:0], 1'b0};
                end
            end
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[addr] <= in_sr;
    end

endmodule
